// File: rtl/cache_read_controller.sv
// Read-only controller for a direct-mapped cache array (256 lines x 16 words x 32b, 20b tag).
// Looks up the array, and on a miss fetches the line from memory, writes it back and
// returns the requested word directly from the assembled line buffer.
module cache_read_controller #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_req_valid,
  output logic         cpu_req_ready,
  input  logic [31:0]  cpu_addr,
  output logic         cpu_resp_valid,
  output logic [31:0]  cpu_rdata,
  output logic         cache_mode,
  output logic [7:0]   cache_index,
  output logic [3:0]   cache_blkoffset,
  output logic [19:0]  cache_tagin,
  output logic [511:0] cache_datain,
  input  logic [31:0]  cache_dataout,
  input  logic [19:0]  cache_tagout,
  input  logic         cache_valid,
  output logic         mem_req,
  output logic [27:0]  mem_addr,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int unsigned TAG_W  = 20;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned OFF_W  = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LINE_W = 512;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_COMPARE,
    S_FILL,
    S_WRITE,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [31:0]         r_addr;
  logic [WAIT_W-1:0]   r_wait;
  logic [OFF_W-1:0]    r_beat;
  logic [LINE_W-1:0]   r_line;

  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_index;
  logic [OFF_W-1:0]    w_offset;
  logic                w_hit;
  logic [LINE_W-1:0]   w_line_merged;
  logic [WORD_W-1:0]   w_fill_word;

  assign w_tag    = r_addr[31:12];
  assign w_index  = r_addr[11:4];
  assign w_offset = r_addr[3:0];
  assign w_hit    = cache_valid && (cache_tagout == w_tag);

  // Line buffer with the current beat merged in, and the requested word from it
  always_comb begin
    w_line_merged = r_line;
    w_line_merged[{r_beat, 5'd0} +: WORD_W] = mem_rdata;
    w_fill_word = w_line_merged[{w_offset, 5'd0} +: WORD_W];
  end

  // Controller FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_wait          <= '0;
      r_beat          <= '0;
      r_line          <= '0;
      cpu_req_ready   <= 1'b1;
      cpu_resp_valid  <= 1'b0;
      cpu_rdata       <= '0;
      cache_mode      <= 1'b0;
      cache_index     <= '0;
      cache_blkoffset <= '0;
      cache_tagin     <= '0;
      cache_datain    <= '0;
      mem_req         <= 1'b0;
      mem_addr        <= '0;
      hit_count       <= '0;
      miss_count      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req_valid) begin
            r_addr          <= cpu_addr;
            r_wait          <= '0;
            cache_mode      <= 1'b0;
            cache_index     <= cpu_addr[11:4];
            cache_blkoffset <= cpu_addr[3:0];
            cpu_req_ready   <= 1'b0;
            r_state         <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (r_wait == WAIT_W'(RD_LAT - 1)) begin
            r_state <= S_COMPARE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end

        S_COMPARE: begin
          if (w_hit) begin
            cpu_rdata      <= cache_dataout;
            cpu_resp_valid <= 1'b1;
            if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + CNT_W'(1);
            r_state        <= S_RESP;
          end else begin
            if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + CNT_W'(1);
            r_beat   <= '0;
            mem_req  <= 1'b1;
            mem_addr <= {w_tag, w_index};
            r_state  <= S_FILL;
          end
        end

        S_FILL: begin
          if (mem_rvalid) begin
            r_line <= w_line_merged;
            r_beat <= r_beat + OFF_W'(1);
            if (r_beat == {OFF_W{1'b1}}) begin
              mem_req      <= 1'b0;
              cache_mode   <= 1'b1;
              cache_index  <= w_index;
              cache_tagin  <= w_tag;
              cache_datain <= w_line_merged;
              cpu_rdata    <= w_fill_word;
              r_state      <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          cache_mode     <= 1'b0;
          cpu_resp_valid <= 1'b1;
          r_state        <= S_RESP;
        end

        S_RESP: begin
          cpu_resp_valid <= 1'b0;
          cpu_req_ready  <= 1'b1;
          r_state        <= S_IDLE;
        end

        default: begin
          cache_mode     <= 1'b0;
          mem_req        <= 1'b0;
          cpu_resp_valid <= 1'b0;
          cpu_req_ready  <= 1'b1;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_read_controller.sv
// Testbench for cache_read_controller: behavioural cache array with 2-cycle read latency,
// table of read transactions, plus async-reset and reset-mid-fill sequences.
module tb_cache_read_controller;

  localparam int unsigned RD_LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cpu_req_valid = 1'b0;
  logic         cpu_req_ready;
  logic [31:0]  cpu_addr = '0;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_rdata;
  logic         cache_mode;
  logic [7:0]   cache_index;
  logic [3:0]   cache_blkoffset;
  logic [19:0]  cache_tagin;
  logic [511:0] cache_datain;
  logic [31:0]  cache_dataout = '0;
  logic [19:0]  cache_tagout = '0;
  logic         cache_valid = 1'b0;
  logic         mem_req;
  logic [27:0]  mem_addr;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  cache_read_controller #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_addr(cpu_addr),
    .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
    .cache_mode(cache_mode), .cache_index(cache_index), .cache_blkoffset(cache_blkoffset),
    .cache_tagin(cache_tagin), .cache_datain(cache_datain),
    .cache_dataout(cache_dataout), .cache_tagout(cache_tagout), .cache_valid(cache_valid),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Cache array model: write on cache_mode, reads valid two cycles after index is driven
  logic [19:0]  m_tag  [256];
  logic [511:0] m_data [256];
  logic [255:0] m_valid = '0;
  logic [11:0]  p1 = '0;

  always @(posedge clk) begin
    if (cache_mode) begin
      m_tag[cache_index]   <= cache_tagin;
      m_data[cache_index]  <= cache_datain;
      m_valid[cache_index] <= 1'b1;
    end
    p1            <= {cache_index, cache_blkoffset};
    cache_tagout  <= m_tag[p1[11:4]];
    cache_valid   <= m_valid[p1[11:4]];
    cache_dataout <= m_data[p1[11:4]][{p1[3:0], 5'd0} +: 32];
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_resp_valid"}, 512'(cpu_resp_valid), 512'(0));
    chk({nm, "_rdata"},      512'(cpu_rdata), 512'(0));
    chk({nm, "_mode"},       512'(cache_mode), 512'(0));
    chk({nm, "_mem_req"},    512'(mem_req), 512'(0));
    chk({nm, "_mem_addr"},   512'(mem_addr), 512'(0));
    chk({nm, "_index"},      512'(cache_index), 512'(0));
    chk({nm, "_offset"},     512'(cache_blkoffset), 512'(0));
    chk({nm, "_tagin"},      512'(cache_tagin), 512'(0));
    chk({nm, "_datain"},     cache_datain, 512'(0));
    chk({nm, "_hits"},       512'(hit_count), 512'(0));
    chk({nm, "_misses"},     512'(miss_count), 512'(0));
    chk({nm, "_ready"},      512'(cpu_req_ready), 512'(1));
  endtask

  // One read transaction; called #1 after a rising edge with the DUT idle
  task automatic run_txn(input string nm, input logic [31:0] addr, input logic [31:0] base,
                         input int gap, input bit spur, input bit exp_hit,
                         input logic [31:0] exp_rdata, input logic [27:0] exp_maddr);
    int c, sent, gcnt, last_c, resp_c, req_c, writes;
    logic [511:0] exp_line, wline;
    logic [27:0]  maddr;
    logic [19:0]  wtag;
    logic [7:0]   widx;
    logic [31:0]  rdata;
    bit           seen_req;
    for (int k = 0; k < 16; k++) exp_line[32*k +: 32] = base + 32'(k);
    sent = 0; gcnt = 0; last_c = -100; resp_c = -1; req_c = -1; writes = 0;
    seen_req = 0; maddr = '0; wtag = '0; widx = '0; wline = '0; rdata = '0;
    if (spur) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
    end
    chk({nm, "_ready"}, 512'(cpu_req_ready), 512'(1));
    cpu_req_valid = 1'b1;
    cpu_addr      = addr;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    c = 1;
    while (c < 300) begin
      if (cache_mode) begin
        writes++;
        wtag = cache_tagin; widx = cache_index; wline = cache_datain;
      end
      if (mem_req && !seen_req) begin
        seen_req = 1; req_c = c; maddr = mem_addr;
      end
      if (cpu_resp_valid) begin
        resp_c = c; rdata = cpu_rdata;
        break;
      end
      if (mem_req && sent < 16) begin
        if (gcnt == 0) begin
          mem_rvalid = 1'b1; mem_rdata = base + 32'(sent); sent++; last_c = c;
        end else begin
          mem_rvalid = 1'b0; mem_rdata = 32'hBAD0_0000;
        end
        gcnt = (gcnt == gap) ? 0 : gcnt + 1;
      end else begin
        mem_rvalid = spur && c[0];
        mem_rdata  = 32'hBAD0_0000;
      end
      @(posedge clk);
      #1;
      c++;
    end
    mem_rvalid = 1'b0;
    chk({nm, "_resp_seen"}, 512'(resp_c >= 0), 512'(1));
    chk({nm, "_rdata"}, 512'(rdata), 512'(exp_rdata));
    if (exp_hit) begin
      exp_hits++;
      chk({nm, "_hit_latency"}, 512'(resp_c), 512'(RD_LAT + 2));
      chk({nm, "_no_mem_req"}, 512'(seen_req), 512'(0));
      chk({nm, "_no_write"}, 512'(writes), 512'(0));
    end else begin
      exp_misses++;
      chk({nm, "_req_cycle"}, 512'(req_c), 512'(RD_LAT + 2));
      chk({nm, "_mem_addr"}, 512'(maddr), 512'(exp_maddr));
      chk({nm, "_writes"}, 512'(writes), 512'(1));
      chk({nm, "_tagin"}, 512'(wtag), 512'(exp_maddr[27:8]));
      chk({nm, "_windex"}, 512'(widx), 512'(exp_maddr[7:0]));
      chk({nm, "_datain"}, wline, exp_line);
      chk({nm, "_miss_latency"}, 512'(resp_c), 512'(last_c + 2));
    end
    chk({nm, "_hit_count"}, 512'(hit_count), 512'(exp_hits));
    chk({nm, "_miss_count"}, 512'(miss_count), 512'(exp_misses));
    @(posedge clk);
    #1;
    chk({nm, "_resp_pulse"}, 512'(cpu_resp_valid), 512'(0));
    chk({nm, "_ready_after"}, 512'(cpu_req_ready), 512'(1));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] base;
    int          gap;
    bit          spur;
    bit          exp_hit;
    logic [31:0] exp_rdata;
    logic [27:0] exp_maddr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int c, sent, writes;
    vecs[0] = '{32'h0001_2345, 32'h100, 0, 1'b0, 1'b0, 32'h105, 28'h0001234}; // cold miss
    vecs[1] = '{32'h0001_2345, 32'h000, 0, 1'b0, 1'b1, 32'h105, 28'h0000000}; // hit
    vecs[2] = '{32'h0002_2340, 32'h200, 0, 1'b0, 1'b0, 32'h200, 28'h0002234}; // conflict
    vecs[3] = '{32'h0001_2345, 32'h300, 2, 1'b1, 1'b0, 32'h305, 28'h0001234}; // evicted, gapped
    vecs[4] = '{32'h0001_234F, 32'h000, 0, 1'b0, 1'b1, 32'h30F, 28'h0000000}; // hit last word
    vecs[5] = '{32'h0003_0000, 32'h400, 1, 1'b1, 1'b0, 32'h400, 28'h0003000}; // index 0
    vecs[6] = '{32'h0003_000A, 32'h000, 0, 1'b0, 1'b1, 32'h40A, 28'h0000000}; // hit

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("v%0d", i), vecs[i].addr, vecs[i].base, vecs[i].gap, vecs[i].spur,
              vecs[i].exp_hit, vecs[i].exp_rdata, vecs[i].exp_maddr);
    end

    // Reset in the middle of a fill: 8 beats delivered, then async reset
    cpu_req_valid = 1'b1;
    cpu_addr      = 32'h0005_6787;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    c = 1; sent = 0; writes = 0;
    while (sent < 8 && c < 100) begin
      if (cache_mode) writes++;
      if (mem_req) begin
        mem_rvalid = 1'b1; mem_rdata = 32'h600 + 32'(sent); sent++;
      end else begin
        mem_rvalid = 1'b0;
      end
      @(posedge clk);
      #1;
      c++;
    end
    mem_rvalid = 1'b0;
    chk("midfill_beats", 512'(sent), 512'(8));
    chk("midfill_req_held", 512'(mem_req), 512'(1));
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midfill_rst");
    repeat (2) begin
      @(posedge clk);
      #1;
      if (cache_mode || cpu_resp_valid) writes++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midfill_no_write", 512'(writes), 512'(0));
    chk("midfill_array_untouched", 512'(m_valid[8'h78]), 512'(0));
    exp_hits = 0;
    exp_misses = 0;
    run_txn("after_rst", 32'h0005_6787, 32'h700, 0, 1'b0, 1'b0, 32'h707, 28'h0005678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
